// File: rtl/instr_encoder_pkg.sv
// Shared instruction-format definitions for the encoder and the control unit decoder.
// Holds op classes, DP command and condition codes, MEM addressing defaults and field positions.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    CLS_DP  = 2'b00,
    CLS_MEM = 2'b01,
    CLS_BR  = 2'b10,
    CLS_ILL = 2'b11
  } op_class_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } enc_state_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Pre-indexed, up, word, no write-back: the only MEM addressing mode the core supports
  localparam logic MEM_P = 1'b1;
  localparam logic MEM_U = 1'b1;
  localparam logic MEM_B = 1'b0;
  localparam logic MEM_W = 1'b0;

  localparam logic [1:0] BR_FUNCT = 2'b10;

  localparam int COND_LSB   = 28;
  localparam int OP_LSB     = 26;
  localparam int I_BIT      = 25;
  localparam int CMD_LSB    = 21;
  localparam int S_BIT      = 20;
  localparam int P_BIT      = 24;
  localparam int U_BIT      = 23;
  localparam int B_BIT      = 22;
  localparam int W_BIT      = 21;
  localparam int L_BIT      = 20;
  localparam int BRF_LSB    = 24;
  localparam int RN_LSB     = 16;
  localparam int RD_LSB     = 12;
  localparam int SRC2_LSB   = 0;
  localparam int IMM24_LSB  = 0;

  function automatic logic dp_cmd_legal(input logic [3:0] cmd);
    return (cmd == CMD_AND) || (cmd == CMD_EOR) || (cmd == CMD_SUB) ||
           (cmd == CMD_ADD) || (cmd == CMD_CMP) || (cmd == CMD_ORR);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: turns instruction fields into a 32-bit word and flags illegal requests.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [1:0]  cls,
  input  logic [3:0]  cond,
  input  logic [3:0]  cmd,
  input  logic        imm,
  input  logic        s,
  input  logic        l,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [11:0] src2,
  input  logic [23:0] imm24,
  output logic [31:0] word,
  output logic        illegal
);

  logic is_cmp;
  assign is_cmp = (cmd == CMD_CMP);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    word[COND_LSB +: 4] = cond;
    word[OP_LSB +: 2]   = cls;
    case (op_class_t'(cls))
      CLS_DP: begin
        // CMP only updates flags, so S is forced and Rd zeroed for the decoder
        word[I_BIT]           = imm;
        word[CMD_LSB +: 4]    = cmd;
        word[S_BIT]           = s | is_cmp;
        word[RN_LSB +: 4]     = rn;
        word[RD_LSB +: 4]     = is_cmp ? 4'h0 : rd;
        word[SRC2_LSB +: 12]  = src2;
        illegal               = !dp_cmd_legal(cmd);
      end
      CLS_MEM: begin
        word[I_BIT]           = ~imm;
        word[P_BIT]           = MEM_P;
        word[U_BIT]           = MEM_U;
        word[B_BIT]           = MEM_B;
        word[W_BIT]           = MEM_W;
        word[L_BIT]           = l;
        word[RN_LSB +: 4]     = rn;
        word[RD_LSB +: 4]     = rd;
        word[SRC2_LSB +: 12]  = src2;
      end
      CLS_BR: begin
        word[BRF_LSB +: 2]    = BR_FUNCT;
        word[IMM24_LSB +: 24] = imm24;
      end
      default: illegal = 1'b1;
    endcase
    if (cond == COND_NV) illegal = 1'b1;
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts field-level instruction requests and writes packed words
// sequentially into instruction memory from address 0 until DEPTH words are stored.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_class,
  input  logic [3:0]    in_cond,
  input  logic [3:0]    in_cmd,
  input  logic          in_imm,
  input  logic          in_s,
  input  logic          in_l,
  input  logic [3:0]    in_rn,
  input  logic [3:0]    in_rd,
  input  logic [11:0]   in_src2,
  input  logic [23:0]   in_imm24,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  enc_state_t  state, state_nx;
  logic [31:0] word;
  logic        illegal;
  logic        drain, last_slot, accept, legal_accept;

  instr_pack u_pack (
    .cls     (in_class),
    .cond    (in_cond),
    .cmd     (in_cmd),
    .imm     (in_imm),
    .s       (in_s),
    .l       (in_l),
    .rn      (in_rn),
    .rd      (in_rd),
    .src2    (in_src2),
    .imm24   (in_imm24),
    .word    (word),
    .illegal (illegal)
  );

  // last_slot: the write now draining fills the final word, so nothing may follow it
  assign drain        = (state == ST_WRITE) && mem_ready;
  assign last_slot    = (count + 1'b1) >= DEPTH_C;
  assign in_ready     = !full && !clear && ((state == ST_IDLE) || (drain && !last_slot));
  assign accept       = in_valid && in_ready;
  assign legal_accept = accept && !illegal;
  assign mem_we       = (state == ST_WRITE);

  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (legal_accept) state_nx = ST_WRITE;
        ST_WRITE: if (mem_ready) state_nx = legal_accept ? ST_WRITE : ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // The address stops on the last word rather than wrapping once memory is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= accept && illegal;
      if (clear) begin
        mem_addr <= '0;
        count    <= '0;
        full     <= 1'b0;
      end else begin
        if (drain) begin
          count <= count + 1'b1;
          full  <= (count + 1'b1) == DEPTH_C;
          if (!last_slot) mem_addr <= mem_addr + 1'b1;
        end
        if (legal_accept) mem_wdata <= word;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed ARM-subset encodings plus randomized
// traffic compared against a queue-based reference model of the loader.
module tb_instr_encoder;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic        valid;
    logic [1:0]  cls;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        imm;
    logic        s;
    logic        l;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_class;
  logic [3:0]    in_cond;
  logic [3:0]    in_cmd;
  logic          in_imm;
  logic          in_s;
  logic          in_l;
  logic [3:0]    in_rn;
  logic [3:0]    in_rd;
  logic [11:0]   in_src2;
  logic [23:0]   in_imm24;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] pend_q[$];
  int          m_count = 0;
  bit          m_err   = 1'b0;

  always #5 clk = ~clk;

  instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_cond   (in_cond),
    .in_cmd    (in_cmd),
    .in_imm    (in_imm),
    .in_s      (in_s),
    .in_l      (in_l),
    .in_rn     (in_rn),
    .in_rd     (in_rd),
    .in_src2   (in_src2),
    .in_imm24  (in_imm24),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .count     (count),
    .full      (full),
    .err       (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: instruction legality and encoding built arithmetically from the ISA rules
  function automatic bit refIllegal(input req_t r);
    bit legal_cmd;
    legal_cmd = (r.cmd == 4'h4) || (r.cmd == 4'h2) || (r.cmd == 4'h0) ||
                (r.cmd == 4'hC) || (r.cmd == 4'hA) || (r.cmd == 4'h1);
    return (r.cond == 4'hF) || (r.cls == 2'd3) || (r.cls == 2'd0 && !legal_cmd);
  endfunction

  function automatic logic [31:0] refWord(input req_t r);
    logic [31:0] w;
    bit          cmp;
    cmp = (r.cmd == 4'hA);
    w = 32'(r.cond) << 28;
    case (r.cls)
      2'd0: w = w + (32'(r.imm) << 25) + (32'(r.cmd) << 21) + (32'(r.s | cmp) << 20)
                  + (32'(r.rn) << 16) + (cmp ? 32'd0 : (32'(r.rd) << 12)) + 32'(r.src2);
      2'd1: w = w + (32'd1 << 26) + (32'(!r.imm) << 25) + (32'd3 << 23) + (32'(r.l) << 20)
                  + (32'(r.rn) << 16) + (32'(r.rd) << 12) + 32'(r.src2);
      default: w = w + (32'hA << 24) + 32'(r.imm24);
    endcase
    return w;
  endfunction

  function automatic req_t mkDp(input logic [3:0] cond, cmd, input logic imm, s,
                                input logic [3:0] rn, rd, input logic [11:0] src2);
    req_t r = '0;
    r.valid = 1'b1; r.cls = 2'd0; r.cond = cond; r.cmd = cmd; r.imm = imm; r.s = s;
    r.rn = rn; r.rd = rd; r.src2 = src2;
    return r;
  endfunction

  function automatic req_t mkMem(input logic [3:0] cond, input logic imm, l,
                                 input logic [3:0] rn, rd, input logic [11:0] src2);
    req_t r = '0;
    r.valid = 1'b1; r.cls = 2'd1; r.cond = cond; r.imm = imm; r.l = l;
    r.rn = rn; r.rd = rd; r.src2 = src2;
    return r;
  endfunction

  function automatic req_t mkBr(input logic [3:0] cond, input logic [23:0] imm24);
    req_t r = '0;
    r.valid = 1'b1; r.cls = 2'd2; r.cond = cond; r.imm24 = imm24;
    return r;
  endfunction

  // One clock cycle: drive at the falling edge, check against the model, then advance the model
  task automatic applyStimulus(input req_t r, input logic mr, input logic clr);
    bit exp_ready, acc;
    @(negedge clk);
    in_valid = r.valid; in_class = r.cls; in_cond = r.cond; in_cmd = r.cmd;
    in_imm = r.imm; in_s = r.s; in_l = r.l; in_rn = r.rn; in_rd = r.rd;
    in_src2 = r.src2; in_imm24 = r.imm24; mem_ready = mr; clear = clr;
    #1;
    exp_ready = (m_count != DEPTH) && !clr &&
                (pend_q.size() == 0 || (mr && (m_count + 1) < DEPTH));
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    checkOutput("mem_we", 32'(mem_we), 32'(pend_q.size() != 0));
    checkOutput("count", 32'(count), 32'(m_count));
    checkOutput("full", 32'(full), 32'(m_count == DEPTH));
    checkOutput("err", 32'(err), 32'(m_err));
    checkOutput("mem_addr", 32'(mem_addr), 32'((m_count < DEPTH) ? m_count : DEPTH - 1));
    if (pend_q.size() != 0) checkOutput("mem_wdata", mem_wdata, pend_q[0]);
    acc = r.valid && exp_ready;
    if (clr) begin
      pend_q.delete();
      m_count = 0;
    end else begin
      if (pend_q.size() != 0 && mr) begin
        void'(pend_q.pop_front());
        m_count++;
      end
      if (acc && !refIllegal(r)) pend_q.push_back(refWord(r));
    end
    m_err = acc && refIllegal(r);
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_t none, rq;
    none = '0;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_class = '0; in_cond = '0; in_cmd = '0;
    in_imm = 1'b0; in_s = 1'b0; in_l = 1'b0; in_rn = '0; in_rd = '0; in_src2 = '0;
    in_imm24 = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD R1,R2,#5
    applyStimulus(mkDp(4'hE, 4'h4, 1'b1, 1'b0, 4'd2, 4'd1, 12'h005), 1'b0, 1'b0);
    afterEdge();
    checkOutput("add_we", 32'(mem_we), 32'd1);
    checkOutput("add_addr", 32'(mem_addr), 32'd0);
    checkOutput("add_word", mem_wdata, 32'hE2821005);
    applyStimulus(none, 1'b1, 1'b0);
    applyStimulus(none, 1'b0, 1'b1);

    // SUBS R3,R3,R4 NE then CMP R0,#0 back-to-back
    applyStimulus(mkDp(4'h1, 4'h2, 1'b0, 1'b1, 4'd3, 4'd3, 12'h004), 1'b1, 1'b0);
    afterEdge();
    checkOutput("subs_word", mem_wdata, 32'h10533004);
    checkOutput("subs_addr", 32'(mem_addr), 32'd0);
    applyStimulus(mkDp(4'hE, 4'hA, 1'b1, 1'b0, 4'd0, 4'd7, 12'h000), 1'b1, 1'b0);
    afterEdge();
    checkOutput("cmp_word", mem_wdata, 32'hE3500000);
    checkOutput("cmp_addr", 32'(mem_addr), 32'd1);
    applyStimulus(none, 1'b1, 1'b0);
    afterEdge();
    checkOutput("pair_count", 32'(count), 32'd2);

    // LDR, STR, B EQ streamed at one word per cycle
    applyStimulus(mkMem(4'hE, 1'b1, 1'b1, 4'd6, 4'd5, 12'h008), 1'b1, 1'b0);
    afterEdge();
    checkOutput("ldr_word", mem_wdata, 32'hE5965008);
    applyStimulus(mkMem(4'hE, 1'b1, 1'b0, 4'd6, 4'd5, 12'h008), 1'b1, 1'b0);
    afterEdge();
    checkOutput("str_word", mem_wdata, 32'hE5865008);
    applyStimulus(mkBr(4'h0, 24'hFFFFFE), 1'b1, 1'b0);
    afterEdge();
    checkOutput("b_word", mem_wdata, 32'h0AFFFFFE);
    applyStimulus(none, 1'b1, 1'b0);

    // Memory stall for three cycles holds the write
    applyStimulus(mkDp(4'hE, 4'h4, 1'b1, 1'b0, 4'd2, 4'd1, 12'h005), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mkDp(4'hE, 4'h0, 1'b0, 1'b0, 4'd1, 4'd1, 12'h001), 1'b0, 1'b0);
      afterEdge();
      checkOutput("stall_word", mem_wdata, 32'hE2821005);
      checkOutput("stall_addr", 32'(mem_addr), 32'd5);
    end
    applyStimulus(none, 1'b1, 1'b0);

    // Illegal requests: bad cmd, class 11, cond NV
    applyStimulus(mkDp(4'hE, 4'hF, 1'b0, 1'b0, 4'd1, 4'd1, 12'h001), 1'b0, 1'b0);
    afterEdge();
    checkOutput("badcmd_err", 32'(err), 32'd1);
    checkOutput("badcmd_we", 32'(mem_we), 32'd0);
    rq = mkBr(4'hE, 24'h000010);
    rq.cls = 2'd3;
    applyStimulus(rq, 1'b0, 1'b0);
    afterEdge();
    checkOutput("class3_err", 32'(err), 32'd1);
    applyStimulus(mkBr(4'hF, 24'h000001), 1'b0, 1'b0);
    applyStimulus(none, 1'b0, 1'b0);
    afterEdge();
    checkOutput("ill_count", 32'(count), 32'd6);

    // Fill to DEPTH
    repeat (3) applyStimulus(mkDp(4'hE, 4'hC, 1'b1, 1'b0, 4'd2, 4'd3, 12'h0FF), 1'b1, 1'b0);
    afterEdge();
    checkOutput("full_flag", 32'(full), 32'd1);
    checkOutput("full_ready", 32'(in_ready), 32'd0);
    checkOutput("full_addr", 32'(mem_addr), 32'(DEPTH - 1));
    applyStimulus(mkDp(4'hE, 4'h4, 1'b1, 1'b0, 4'd2, 4'd1, 12'h005), 1'b1, 1'b0);

    // Clear abandons a stalled write
    applyStimulus(none, 1'b0, 1'b1);
    applyStimulus(mkDp(4'hE, 4'h4, 1'b1, 1'b0, 4'd2, 4'd1, 12'h005), 1'b0, 1'b0);
    applyStimulus(none, 1'b0, 1'b0);
    applyStimulus(none, 1'b0, 1'b1);
    afterEdge();
    checkOutput("clr_we", 32'(mem_we), 32'd0);
    checkOutput("clr_addr", 32'(mem_addr), 32'd0);
    checkOutput("clr_count", 32'(count), 32'd0);

    // Asynchronous reset in the middle of a write
    applyStimulus(mkDp(4'hE, 4'h4, 1'b1, 1'b0, 4'd2, 4'd1, 12'h005), 1'b1, 1'b0);
    applyStimulus(mkDp(4'hE, 4'h1, 1'b0, 1'b0, 4'd2, 4'd1, 12'h005), 1'b0, 1'b0);
    afterEdge();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_we", 32'(mem_we), 32'd0);
    checkOutput("arst_addr", 32'(mem_addr), 32'd0);
    checkOutput("arst_wdata", mem_wdata, 32'd0);
    checkOutput("arst_count", 32'(count), 32'd0);
    pend_q.delete();
    m_count = 0;
    m_err = 1'b0;
    #1 rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int sel;
      bit mr, clr;
      rq = '0;
      rq.valid = ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 7);
      rq.cls = (sel < 3) ? 2'd0 : (sel < 5) ? 2'd1 : (sel < 7) ? 2'd2 : 2'd3;
      rq.cond = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      case ($urandom_range(0, 6))
        0: rq.cmd = 4'h4;
        1: rq.cmd = 4'h2;
        2: rq.cmd = 4'h0;
        3: rq.cmd = 4'hC;
        4: rq.cmd = 4'hA;
        5: rq.cmd = 4'h1;
        default: rq.cmd = 4'($urandom);
      endcase
      rq.imm = 1'($urandom); rq.s = 1'($urandom); rq.l = 1'($urandom);
      rq.rn = 4'($urandom); rq.rd = 4'($urandom);
      rq.src2 = 12'($urandom); rq.imm24 = 24'($urandom);
      mr = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 39) == 0) || (m_count == DEPTH && $urandom_range(0, 2) == 0);
      applyStimulus(rq, mr, clr);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
